acualu_arbiter: RTL
===================

Name: acualu_arbiter

Overview:
- Round-robin arbiter/sequencer that shares the single accumulator ALU among N_REQ requesters.
- Per requester, accepts one {op, operand} job over a valid/ready handshake. Drives the ALU op/data_in for one cycle, waits the ALU latency, then captures data_out/zero. Returns the result to the granted requester over a valid/ready response channel.
- Sits between the requester masters and the ALU datapath. Exactly one job is in flight at a time.

Parameters:
- N_REQ, 4, number of requesters (2..8)
- DATA_W, 16, ALU data width
- OP_W, 8, ALU opcode width
- ALU_LAT, 1, cycles from ALU op issue to data_out/zero valid (>=1)

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-low reset
- req_valid  in  N_REQ  job request per requester
- req_ready  out  N_REQ  one-hot accept, combinational in IDLE
- req_op  in  N_REQ*OP_W  packed opcodes, requester i at [i*OP_W +: OP_W]
- req_data  in  N_REQ*DATA_W  packed operands
- rsp_valid  out  N_REQ  one-hot result valid
- rsp_ready  in  N_REQ  result accept per requester
- rsp_data  out  DATA_W  captured ALU result
- rsp_zero  out  1  captured ALU zero flag
- alu_op  out  OP_W  to ALU op
- alu_data_in  out  DATA_W  to ALU data_in
- alu_data_out  in  DATA_W  from ALU data_out
- alu_zero  in  1  from ALU zero
- grant_id  out  $clog2(N_REQ)  index of current/last granted requester
- busy  out  1  high in every state except IDLE

Behaviour:
- Reset (rst low, async): state=IDLE; req_ready=0 (forced 0 while rst low); rsp_valid=0; rsp_data=0; rsp_zero=0; alu_op=OP_NOP (8'h00); alu_data_in=0; grant_id=0; busy=0; cnt=0; rr pointer last=N_REQ-1, so requester 0 has first priority.
- FSM states are IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - Winner = first i with req_valid[i] high, scanning (last+1) mod N_REQ upward with wrap.
  - req_ready[winner]=1; all other bits 0. If no req_valid, req_ready=0.
  - On the handshake edge: latch op/data of winner; grant_id<=winner; last<=winner; go to ISSUE.
- ISSUE (1 cycle): alu_op=latched op; alu_data_in=latched data. cnt<=ALU_LAT-1; go to WAIT.
- WAIT (ALU_LAT cycles): alu_op=OP_NOP and alu_data_in=0.
  - If cnt==0: rsp_data<=alu_data_out; rsp_zero<=alu_zero; go to RESP.
  - Else: cnt<=cnt-1.
- RESP: rsp_valid[grant_id]=1 (registered, one-hot). Hold rsp_data/rsp_zero stable until rsp_ready[grant_id]. On that edge: rsp_valid<=0; go to IDLE.
- Latency: the req handshake at edge T0 gives rsp_valid high in cycle T0+ALU_LAT+2. Back-to-back throughput is one job per ALU_LAT+3 cycles minimum.
- Outside ISSUE, alu_op is always OP_NOP and alu_data_in is always 0.
- Boundary conditions:
  - req_valid dropped before its grant: legal, no effect.
  - req_valid[i] held while i is busy: no second accept until the FSM returns to IDLE.
  - rsp_ready on non-granted lines: ignored.
  - rsp_ready low indefinitely: FSM stays in RESP; no new grants.
  - Requester i with a response pending in RESP may present a new request simultaneously. It is arbitrated only in the next IDLE cycle, and its priority is then lowest (pointer already = i).
  - Pointer wrap: last=N_REQ-1 wraps to a scan starting at 0.
  - Reset asserted mid-ISSUE/WAIT/RESP: in-flight job discarded; no rsp_valid after reset release.

Decomposition:
- Package acualu_pkg:
  - OP_NOP constant
  - state_t enum {IDLE, ISSUE, WAIT, RESP}
  - default DATA_W/OP_W localparams
- Sub-module rr_arbiter: combinational round-robin picker. Inputs: req vector and last pointer. Outputs: one-hot grant, grant index, any-valid flag. The pointer register stays in acualu_arbiter.

Test Plan:
- Single job: req_valid=4'b0001, op=8'h01, data=16'h0005; ALU model returns 16'h0005, zero=0 -> alu_op=8'h01 only in cycle T0+1; rsp_valid=4'b0001 at T0+3 with rsp_data=16'h0005 and rsp_zero=0.
- All four req_valid held, rsp_ready=4'b1111 -> grant order 0,1,2,3,0,1,2,3; exactly one rsp_valid bit per job.
- Fairness: req 1 and 3 held; req 0 pulses after the grant to 1 -> next grants are 3, then 0, then 1.
- Backpressure: rsp_ready[0]=0 for 5 cycles after rsp_valid[0] -> rsp_valid/rsp_data stable; req_ready=0 for all; alu_op=8'h00; busy=1.
- Zero flag: ALU returns 16'h0000 with zero=1 -> rsp_zero=1 and rsp_data=16'h0000. Next job returning 16'h00FF with zero=0 -> rsp_zero=0.
- Reset in WAIT -> all outputs immediately at reset values. After release with only req_valid[2] high -> grant_id=2; stale result never delivered.

Source files
------------

// File: rtl/acualu_pkg.sv
// Shared types and constants for the accumulator-ALU arbiter slice.
package acualu_pkg;

  localparam int unsigned DEF_DATA_W = 16;
  localparam int unsigned DEF_OP_W   = 8;

  // Opcode that leaves the ALU accumulator untouched.
  localparam logic [7:0] OP_NOP = 8'h00;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

endpackage

// File: rtl/acualu_arbiter_rr.sv
// Combinational round-robin picker: first requester after 'last', with wrap.
module rr_arbiter #(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned IW    = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IW-1:0]    last,
  output logic [N_REQ-1:0] gnt,
  output logic [IW-1:0]    gnt_idx,
  output logic             any
);

  logic [IW-1:0] idx;

  // Scan last+1, last+2, ... (mod N_REQ); the first requester seen wins.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    any     = 1'b0;
    idx     = '0;
    for (int unsigned k = 1; k <= N_REQ; k++) begin
      idx = IW'((32'(last) + k) % N_REQ);
      if (!any && req[idx]) begin
        any      = 1'b1;
        gnt[idx] = 1'b1;
        gnt_idx  = idx;
      end
    end
  end

endmodule

// File: rtl/acualu_arbiter.sv
// Round-robin sequencer sharing one accumulator ALU among N_REQ requesters.
// One job in flight: accept, issue for one cycle, wait ALU_LAT, respond.
module acualu_arbiter
  import acualu_pkg::*;
#(
  parameter int unsigned N_REQ   = 4,
  parameter int unsigned DATA_W  = DEF_DATA_W,
  parameter int unsigned OP_W    = DEF_OP_W,
  parameter int unsigned ALU_LAT = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [N_REQ-1:0]          req_valid,
  output logic [N_REQ-1:0]          req_ready,
  input  logic [N_REQ*OP_W-1:0]     req_op,
  input  logic [N_REQ*DATA_W-1:0]   req_data,
  output logic [N_REQ-1:0]          rsp_valid,
  input  logic [N_REQ-1:0]          rsp_ready,
  output logic [DATA_W-1:0]         rsp_data,
  output logic                      rsp_zero,
  output logic [OP_W-1:0]           alu_op,
  output logic [DATA_W-1:0]         alu_data_in,
  input  logic [DATA_W-1:0]         alu_data_out,
  input  logic                      alu_zero,
  output logic [$clog2(N_REQ)-1:0]  grant_id,
  output logic                      busy
);

  localparam int unsigned IW    = $clog2(N_REQ);
  localparam int unsigned CNT_W = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;

  state_t              state_q, state_d;
  logic [IW-1:0]       last_q, last_d;
  logic [IW-1:0]       grant_id_q, grant_id_d;
  logic [OP_W-1:0]     op_q, op_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [N_REQ-1:0]    rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]   rsp_data_q, rsp_data_d;
  logic                rsp_zero_q, rsp_zero_d;

  logic [N_REQ-1:0]    arb_gnt;
  logic [IW-1:0]       arb_idx;
  logic                arb_any;

  rr_arbiter #(
    .N_REQ (N_REQ),
    .IW    (IW)
  ) u_rr (
    .req     (req_valid),
    .last    (last_q),
    .gnt     (arb_gnt),
    .gnt_idx (arb_idx),
    .any     (arb_any)
  );

  // Next-state, datapath capture and ALU/handshake outputs.
  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    grant_id_d  = grant_id_q;
    op_d        = op_q;
    data_d      = data_q;
    cnt_d       = cnt_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    rsp_zero_d  = rsp_zero_q;
    req_ready   = '0;
    alu_op      = OP_W'(OP_NOP);
    alu_data_in = '0;

    unique case (state_q)
      IDLE: begin
        // Ready is only offered to the winner, so a winner means a handshake.
        if (rst) req_ready = arb_gnt;
        if (arb_any) begin
          for (int unsigned i = 0; i < N_REQ; i++) begin
            if (arb_gnt[i]) begin
              op_d   = req_op[i*OP_W +: OP_W];
              data_d = req_data[i*DATA_W +: DATA_W];
            end
          end
          grant_id_d = arb_idx;
          last_d     = arb_idx;
          state_d    = ISSUE;
        end
      end
      ISSUE: begin
        alu_op      = op_q;
        alu_data_in = data_q;
        cnt_d       = CNT_W'(ALU_LAT - 1);
        state_d     = WAIT;
      end
      WAIT: begin
        if (cnt_q == '0) begin
          rsp_data_d = alu_data_out;
          rsp_zero_d = alu_zero;
          for (int unsigned i = 0; i < N_REQ; i++) begin
            rsp_valid_d[i] = (32'(grant_id_q) == i);
          end
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      RESP: begin
        if (rsp_ready[grant_id_q]) begin
          rsp_valid_d = '0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; async reset discards any in-flight job.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      last_q      <= IW'(N_REQ - 1);
      grant_id_q  <= '0;
      op_q        <= OP_W'(OP_NOP);
      data_q      <= '0;
      cnt_q       <= '0;
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
      rsp_zero_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      grant_id_q  <= grant_id_d;
      op_q        <= op_d;
      data_q      <= data_d;
      cnt_q       <= cnt_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_zero_q  <= rsp_zero_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_zero  = rsp_zero_q;
  assign grant_id  = grant_id_q;
  assign busy      = (state_q != IDLE);

endmodule
